// File: rtl/cam_pkg.sv
// Shared constants, state encoding and RGB565->RGB444 slice positions for the
// OV7670 capture path.
package cam_pkg;

    localparam int c_qqvga_cols = 160;
    localparam int c_qqvga_rows = 120;
    localparam int c_vga_cols   = 640;
    localparam int c_vga_rows   = 480;

    localparam int c_img_cols    = c_qqvga_cols;
    localparam int c_img_rows    = c_qqvga_rows;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = $clog2(c_img_pxls);

    localparam int c_nb_buf_red   = 4;
    localparam int c_nb_buf_green = 4;
    localparam int c_nb_buf_blue  = 4;
    localparam int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue;

    // RGB565 arrives as b1 = RRRRRGGG, b2 = GGGBBBBB; keep the top bits of each channel
    localparam int c_r_msb   = 7;
    localparam int c_r_lsb   = 4;
    localparam int c_g1_msb  = 2;
    localparam int c_g1_lsb  = 0;
    localparam int c_g2_bit  = 7;
    localparam int c_b_msb   = 4;
    localparam int c_b_lsb   = 1;

    typedef enum logic [1:0] {
        WAIT_VS  = 2'd0,
        WAIT_FRM = 2'd1,
        CAPTURE  = 2'd2
    } cam_state_t;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera input bundle plus frame-buffer write port A, as seen by the capture stage.
interface ov7670_capture_if #(
    parameter int ADDR_W = cam_pkg::c_nb_img_pxls,
    parameter int DATA_W = cam_pkg::c_nb_buf
);
    logic              cam_pclk;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              frame_done;

    // master: camera + frame buffer side; slave: the capture block
    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  wea, addra, dina, frame_done
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output wea, addra, dina, frame_done
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a third tap for rise/fall detection, per bit.
module sync_edge #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall
);
    logic [DATA_W-1:0] sync_p1;
    logic [DATA_W-1:0] sync_p2;
    logic [DATA_W-1:0] sync_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            sync_p3 <= '0;
        end else begin
            sync_p1 <= d;
            sync_p2 <= sync_p1;
            sync_p3 <= sync_p2;
        end
    end

    // stage 2 is the synchronised value; stage 3 only serves edge detection
    assign q    = sync_p2;
    assign rise = sync_p2 & ~sync_p3;
    assign fall = ~sync_p2 & sync_p3;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel-stream capture: syncs the camera bus into clk, packs each
// RGB565 byte pair into RGB444 and writes it to the frame buffer in raster order.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int IMG_COLS = c_img_cols,
    parameter int IMG_ROWS = c_img_rows
) (
    input  logic             clk,
    input  logic             rst_n,
    ov7670_capture_if.slave  bus
);
    localparam int ADDR_W = $clog2(IMG_COLS * IMG_ROWS);
    localparam int COL_W  = $clog2(c_vga_cols + 1);
    localparam int ROW_W  = $clog2(c_vga_rows + 1);
    localparam int SYNC_W = 11;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_COLS * IMG_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(IMG_COLS);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_ROWS);

    function automatic logic [c_nb_buf-1:0] pack_rgb444(input logic [7:0] b1,
                                                        input logic [7:0] b2);
        return {b1[c_r_msb:c_r_lsb], b1[c_g1_msb:c_g1_lsb], b2[c_g2_bit],
                b2[c_b_msb:c_b_lsb]};
    endfunction

    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0] sync_rise;
    logic [SYNC_W-1:0] sync_fall;

    logic       pclk_rise;
    logic       vsync_s;
    logic       vsync_fall;
    logic       href_s;
    logic       href_fall;
    logic [7:0] data_s;
    logic       unused_edges;

    cam_state_t       state_q;
    cam_state_t       state_d;
    logic             phase_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [7:0]       b1_p1;

    logic frm_start;
    logic take_b1;
    logic take_b2;
    logic line_end;
    logic frm_end;
    logic in_win;

    // all four camera signals share one chain so data stays aligned with pclk
    assign sync_in = {bus.cam_data, bus.cam_href, bus.cam_vsync, bus.cam_pclk};

    sync_edge #(
        .DATA_W (SYNC_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_q),
        .rise  (sync_rise),
        .fall  (sync_fall)
    );

    assign pclk_rise  = sync_rise[0];
    assign vsync_s    = sync_q[1];
    assign vsync_fall = sync_fall[1];
    assign href_s     = sync_q[2];
    assign href_fall  = sync_fall[2];
    assign data_s     = sync_q[10:3];

    assign unused_edges = ^{sync_q[0], sync_rise[10:1], sync_fall[10:3], sync_fall[0]};

    assign in_win = (col_q < COL_END) && (row_q < ROW_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frm_start = 1'b0;
        take_b1   = 1'b0;
        take_b2   = 1'b0;
        line_end  = 1'b0;
        frm_end   = 1'b0;
        unique case (state_q)
            WAIT_VS: begin
                if (vsync_s) begin
                    state_d = WAIT_FRM;
                end
            end
            WAIT_FRM: begin
                if (vsync_fall) begin
                    frm_start = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                // a completed frame wins over an early vsync seen in the same cycle
                if (row_q == ROW_END) begin
                    frm_end = 1'b1;
                    state_d = WAIT_FRM;
                end else if (vsync_s) begin
                    state_d = WAIT_FRM;
                end else begin
                    take_b1  = pclk_rise && href_s && !phase_q;
                    take_b2  = pclk_rise && href_s && phase_q;
                    line_end = href_fall;
                end
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    // pixel stage: first byte held until its partner arrives
    always_ff @(posedge clk) begin
        if (take_b1) begin
            b1_p1 <= data_s;
        end
    end

    // write stage: counters, strobe and packed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            bus.wea        <= 1'b0;
            bus.addra      <= '0;
            bus.dina       <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.wea        <= 1'b0;
            bus.frame_done <= frm_end;
            if (frm_start) begin
                phase_q   <= 1'b0;
                col_q     <= '0;
                row_q     <= '0;
                bus.addra <= '0;
            end else begin
                if (bus.wea && (bus.addra != ADDR_LAST)) begin
                    bus.addra <= bus.addra + 1'b1;
                end
                if (take_b1) begin
                    phase_q <= 1'b1;
                end
                if (take_b2) begin
                    phase_q <= 1'b0;
                    if (in_win) begin
                        bus.wea  <= 1'b1;
                        bus.dina <= pack_rgb444(b1_p1, data_s);
                    end
                    if (col_q < COL_END) begin
                        col_q <= col_q + 1'b1;
                    end
                end
                // a dangling first byte is dropped here; empty lines do not count
                if (line_end) begin
                    phase_q <= 1'b0;
                    col_q   <= '0;
                    if (col_q != '0) begin
                        row_q <= row_q + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 16x6 frame.
module tb_ov7670_capture;
    localparam int COLS   = 16;
    localparam int ROWS   = 6;
    localparam int PXLS   = COLS * ROWS;
    localparam int ADDR_W = $clog2(PXLS);

    logic clk;
    logic rst_n;

    ov7670_capture_if #(.ADDR_W(ADDR_W), .DATA_W(12)) bus ();

    ov7670_capture #(
        .IMG_COLS (COLS),
        .IMG_ROWS (ROWS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int exp_addr = 0;
    int last_addr = -1;
    int max_addr = -1;

    logic [7:0]  b1_tab [0:8][0:19];
    logic [7:0]  b2_tab [0:8][0:19];
    logic [11:0] exp_mem [0:PXLS-1];
    logic [11:0] cap_dina [0:1];

    function automatic logic [11:0] tb_pack(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
    endfunction

    function automatic logic [7:0] gen_b1(input int r, input int c);
        return 8'(((r * 37) + (c * 11) + 5) ^ 32'h5A);
    endfunction

    function automatic logic [7:0] gen_b2(input int r, input int c);
        return 8'((r * 13) + (c * 29) + 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    // write monitor: every strobe must carry the next raster address and its word
    always @(negedge clk) begin
        if (bus.wea === 1'b1) begin
            checks++;
            assert (bus.addra === ADDR_W'(exp_addr)) else begin
                errors++;
                $error("FAIL wr_addr got %0d want %0d", bus.addra, exp_addr);
            end
            checks++;
            assert (bus.dina === exp_mem[exp_addr % PXLS]) else begin
                errors++;
                $error("FAIL wr_dina at %0d got %03h want %03h", exp_addr, bus.dina,
                       exp_mem[exp_addr % PXLS]);
            end
            if (bus.addra < 2) cap_dina[bus.addra[0]] = bus.dina;
            last_addr = int'(bus.addra);
            if (last_addr > max_addr) max_addr = last_addr;
            wr_cnt++;
            exp_addr++;
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    task automatic set_frame(input int mode);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 20; c++) begin
                b1_tab[r][c] = (mode == 0) ? 8'hF8 : gen_b1(r, c);
                b2_tab[r][c] = (mode == 0) ? 8'h1F : gen_b2(r, c);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp_mem[r*COLS + c] = (mode == 0) ? 12'hF0F : tb_pack(b1_tab[r][c], b2_tab[r][c]);
            end
        end
        if (mode == 2) begin
            b1_tab[0][0] = 8'h07; b2_tab[0][0] = 8'hE0; exp_mem[0] = 12'h0F0;
            b1_tab[0][1] = 8'h00; b2_tab[0][1] = 8'h00; exp_mem[1] = 12'h000;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.cam_pclk = 1'b0;
        bus.cam_data = b;
        @(negedge clk);
        @(negedge clk);
        bus.cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wea", 32'(bus.wea), 32'd0);
        chk("midrst_addra", 32'(bus.addra), 32'd0);
        wr_cnt = 0;
        fd_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_line(input int r, input int nbytes, input int rst_at);
        @(negedge clk);
        bus.cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            if (i == rst_at) do_reset();
            send_byte((i % 2 == 0) ? b1_tab[r][i/2] : b2_tab[r][i/2]);
        end
        @(negedge clk);
        bus.cam_pclk = 1'b0;
        @(negedge clk);
        bus.cam_href = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input int ncols, input int nrows, input int odd_row,
                              input int rst_row);
        @(negedge clk);
        bus.cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        wr_cnt = 0;
        fd_cnt = 0;
        exp_addr = 0;
        last_addr = -1;
        max_addr = -1;
        bus.cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        for (int r = 0; r < nrows; r++) begin
            send_line(r, 2*ncols + ((r == odd_row) ? 1 : 0), (r == rst_row) ? 10 : -1);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cam_pclk  = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        cap_dina[0]   = 12'hFFF;
        cap_dina[1]   = 12'hFFF;
        repeat (3) @(negedge clk);
        chk("rst_wea", 32'(bus.wea), 32'd0);
        chk("rst_addra", 32'(bus.addra), 32'd0);
        chk("rst_dina", 32'(bus.dina), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // red+blue constant frame
        set_frame(0);
        send_frame(COLS, ROWS, -1, -1);
        chk("t1_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t1_last_addr", 32'(last_addr), 32'(PXLS - 1));
        chk("t1_frame_done", 32'(fd_cnt), 32'd1);

        // pure green then black at the first two addresses
        set_frame(2);
        send_frame(COLS, ROWS, -1, -1);
        chk("t2_pix0", 32'(cap_dina[0]), 32'h0F0);
        chk("t2_pix1", 32'(cap_dina[1]), 32'h000);
        chk("t2_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t2_frame_done", 32'(fd_cnt), 32'd1);

        // oversize lines and rows are clipped
        set_frame(1);
        send_frame(COLS + 4, ROWS + 3, -1, -1);
        chk("t3_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t3_max_addr", 32'(max_addr), 32'(PXLS - 1));
        chk("t3_frame_done", 32'(fd_cnt), 32'd1);

        // early vsync after 3 lines, then a normal frame
        send_frame(COLS, 3, -1, -1);
        @(negedge clk);
        bus.cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_partial_writes", 32'(wr_cnt), 32'(3 * COLS));
        chk("t4_no_frame_done", 32'(fd_cnt), 32'd0);
        send_frame(COLS, ROWS, -1, -1);
        chk("t4_next_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t4_next_last_addr", 32'(last_addr), 32'(PXLS - 1));
        chk("t4_next_frame_done", 32'(fd_cnt), 32'd1);

        // reset during line 2: the remainder of that frame must not be written
        send_frame(COLS, ROWS, -1, 2);
        chk("t5_writes_after_rst", 32'(wr_cnt), 32'd0);
        chk("t5_no_frame_done", 32'(fd_cnt), 32'd0);
        send_frame(COLS, ROWS, -1, -1);
        chk("t5_clean_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t5_clean_frame_done", 32'(fd_cnt), 32'd1);

        // line 2 carries an odd byte count
        set_frame(1);
        send_frame(COLS, ROWS, 2, -1);
        chk("t6_writes", 32'(wr_cnt), 32'(PXLS));
        chk("t6_last_addr", 32'(last_addr), 32'(PXLS - 1));
        chk("t6_frame_done", 32'(fd_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
